mc_control_fsm: RTL

Multicycle control unit that drives the ALU's `ALUControl` select and consumes its `Zero` flag. It sequences each MIPS instruction through fetch, decode, execute, memory and writeback states, issuing datapath mux selects and write enables one state per clock. It sits beside the shared datapath (register file, ALU, instruction/data memory, PC, IR, A/B/ALUOut registers) of the multicycle core.

---
 rtl/mc_control_fsm_if.sv | 38 +++
 rtl/mc_control_fsm.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm_if
// Description : Instruction fields, ALU flag and datapath control bundle
//               shared by the multicycle control unit and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mc_control_fsm_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCEn;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Opcode, Funct, Zero,
        output ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
               IRWrite, MemWrite, RegWrite, PCEn, IllegalOp, State
    );

    modport slave (
        output Opcode, Funct, Zero,
        input  ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg,
               IRWrite, MemWrite, RegWrite, PCEn, IllegalOp, State
    );
endinterface
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multicycle MIPS control unit; sequences fetch/decode/execute/
//               memory/writeback and issues datapath selects and enables.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm (
    input  wire logic        CLK,
    input  wire logic        RST,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
    } ctrl_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b110;
    localparam logic [2:0] c_ALU_XOR = 3'b111;

    state_t state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   funct_bad_q, funct_bad_d;
    logic   w_funct_bad;
    logic   w_opcode_bad;
    logic   w_branch_taken;
    logic [2:0] w_funct_alu;

    // Moore control word for a given state; funct_alu only matters in EXECR.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [2:0] funct_alu);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b   = 2'b01;
                c.alu_control = c_ALU_ADD;
                c.ir_write    = 1'b1;
                c.pc_write    = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b   = 2'b11;
                c.alu_control = c_ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'b10;
                c.alu_control = c_ALU_ADD;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_alu;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = c_ALU_SUB;
                c.pc_src      = 2'b01;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_funct_bad = 1'b0;
        case (bus.Funct)
            6'b100000: w_funct_alu = c_ALU_ADD;
            6'b100010: w_funct_alu = c_ALU_SUB;
            6'b100100: w_funct_alu = c_ALU_AND;
            6'b100101: w_funct_alu = c_ALU_OR;
            6'b100110: w_funct_alu = c_ALU_XOR;
            6'b101010: w_funct_alu = c_ALU_SLT;
            default: begin
                w_funct_alu = c_ALU_ADD;
                w_funct_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        case (bus.Opcode)
            c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ,
            c_OP_BNE, c_OP_ADDI, c_OP_J:            w_opcode_bad = 1'b0;
            default:                                w_opcode_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Opcode)
                    c_OP_LW, c_OP_SW:   state_d = S_MEMADR;
                    c_OP_RTYPE:         state_d = S_EXECR;
                    c_OP_BEQ, c_OP_BNE: state_d = S_BRANCH;
                    c_OP_ADDI:          state_d = S_ADDIEX;
                    c_OP_J:             state_d = S_JUMP;
                    default:            state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.Opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase

        ctrl_d      = decode_ctrl(state_d, w_funct_alu);
        funct_bad_d = (state_q == S_EXECR) ? w_funct_bad : funct_bad_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_FETCH;
            ctrl_q      <= decode_ctrl(S_FETCH, c_ALU_ADD);
            funct_bad_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            funct_bad_q <= funct_bad_d;
        end
    end

    // Zero only influences the PC through this term, and only in BRANCH.
    assign w_branch_taken = (state_q == S_BRANCH) &&
                            (((bus.Opcode == c_OP_BEQ) &&  bus.Zero) ||
                             ((bus.Opcode == c_OP_BNE) && !bus.Zero));

    assign bus.ALUControl = ctrl_q.alu_control;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ALUSrcB    = ctrl_q.alu_src_b;
    assign bus.PCSrc      = ctrl_q.pc_src;
    assign bus.IorD       = ctrl_q.iord;
    assign bus.RegDst     = ctrl_q.reg_dst;
    assign bus.MemtoReg   = ctrl_q.mem_to_reg;
    assign bus.IRWrite    = !RST && ctrl_q.ir_write;
    assign bus.MemWrite   = !RST && ctrl_q.mem_write;
    assign bus.RegWrite   = !RST && ctrl_q.reg_write &&
                            !((state_q == S_ALUWB) && funct_bad_q);
    assign bus.PCEn       = !RST && (ctrl_q.pc_write || w_branch_taken);
    assign bus.IllegalOp  = !RST && (((state_q == S_DECODE) && w_opcode_bad) ||
                                     ((state_q == S_EXECR)  && w_funct_bad));
    assign bus.State      = state_q;

endmodule
`default_nettype wire
